// File: rtl/rom_prefetch_pkg.sv
// Shared constants for the ROM prefetch stage.
// QUIT_OPCODE is only consulted when PREFETCH_QUIT_STOP_EN is defined.
package rom_prefetch_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int WORD_W_DEF = 8;

    localparam logic [7:0] QUIT_OPCODE = 8'h0E;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rom_prefetch_if.sv
// Core-side instruction handshake: head byte, its PC, valid/ready.
// master = prefetch stage, slave = decoder.
interface rom_prefetch_if #(
    parameter int ADDR_W = 5,
    parameter int WORD_W = 8
);

    logic              instr_valid;
    logic [WORD_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;

    modport master (
        output instr_valid,
        output instr_data,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_data,
        input  instr_pc,
        output instr_ready
    );

endinterface

// File: rtl/rom_prefetch_fifo.sv
// First-word-fall-through FIFO with synchronous clear for fetched bytes.
// Head reads as zero while empty.
module prefetch_fifo
    import rom_prefetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          head,
    output logic                      head_valid,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign head_valid = (count != '0);
    assign full       = (count == CW'(DEPTH));
    assign push_ok    = push && !full;
    assign pop_ok     = pop && head_valid;
    assign head       = head_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // The credit scheme upstream must never push into a full FIFO.
    ovf_a: assert property (@(posedge clk) disable iff (!reset)
        !(push && full && !clear));

endmodule

// File: rtl/rom_prefetch.sv
// Instruction prefetch between a registered-read ROM and the decoder.
// PREFETCH_QUIT_STOP_EN: stop fetching after capturing the quit opcode.
module rom_prefetch
    import rom_prefetch_pkg::*;
#(
    parameter int              ADDR_W   = ADDR_W_DEF,
    parameter int              WORD_W   = WORD_W_DEF,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_enable_out,
    input  logic [WORD_W-1:0] rom_data,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    rom_prefetch_if.master    core,
    output logic              halted
);

    localparam int CW = cnt_w(DEPTH);
    localparam int FW = WORD_W + ADDR_W;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              issue;
    logic              push;
    logic              pop;
    logic              quit_cap;
    logic [CW:0]       used;
    logic [CW-1:0]     count;
    logic [FW-1:0]     head;
    logic              head_valid;
    logic              fifo_full;

    assign rom_addr       = fetch_pc;
    assign rom_enable_out = inflight;

    assign push = inflight && !jump;
    assign pop  = head_valid && core.instr_ready && !jump;

    // Credits include the outstanding ROM read so a capture always fits.
    assign used  = {1'b0, count} + (CW + 1)'(inflight);
    assign issue = reset && !jump && !halted && !quit_cap
                && (used < (CW + 1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (jump) begin
            fetch_pc    <= jump_addr;
            inflight    <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + ADDR_W'(1);
            end
        end
    end

`ifdef PREFETCH_QUIT_STOP_EN
    logic halt_q;

    assign quit_cap = push && (rom_data == WORD_W'(QUIT_OPCODE));
    assign halted   = halt_q;

    always_ff @(posedge clk) begin
        if (!reset || jump) begin
            halt_q <= 1'b0;
        end else if (quit_cap) begin
            halt_q <= 1'b1;
        end
    end
`else
    assign quit_cap = 1'b0;
    assign halted   = 1'b0;
`endif

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (jump),
        .push       (push),
        .push_data  ({rom_data, inflight_pc}),
        .pop        (pop),
        .head       (head),
        .head_valid (head_valid),
        .count      (count),
        .full       (fifo_full)
    );

    assign core.instr_valid = head_valid;
    assign core.instr_data  = head[FW-1:ADDR_W];
    assign core.instr_pc    = head[ADDR_W-1:0];

endmodule

// File: tb/tb_rom_prefetch.sv
// Directed bench for rom_prefetch: vector table plus quit/halt sequence.
// Quit expectations follow PREFETCH_QUIT_STOP_EN.
module tb_rom_prefetch;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rom_addr;
    logic       rom_enable_out;
    logic [7:0] rom_q;
    logic       jump;
    logic [4:0] jump_addr;
    logic       halted;
    logic [7:0] rom_mem [32];

    int errors = 0;
    int checks = 0;

    rom_prefetch_if #(.ADDR_W(5), .WORD_W(8)) core_if ();

    rom_prefetch #(
        .ADDR_W   (5),
        .WORD_W   (8),
        .DEPTH    (4),
        .RESET_PC (5'd0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rom_addr       (rom_addr),
        .rom_enable_out (rom_enable_out),
        .rom_data       (rom_q),
        .jump           (jump),
        .jump_addr      (jump_addr),
        .core           (core_if),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    // Registered-read ROM: data appears the cycle after the address edge.
    always @(posedge clk) rom_q <= rom_mem[rom_addr];

    typedef struct {
        logic       rst;
        logic       rdy;
        logic       jmp;
        logic [4:0] ja;
        logic       ev;
        logic [7:0] ed;
        logic [4:0] ep;
        logic       een;
        logic [4:0] ea;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic rdy, logic jmp,
                                logic [4:0] ja, logic ev,
                                logic [7:0] ed, logic [4:0] ep,
                                logic een, logic [4:0] ea);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.jmp = jmp; v.ja = ja;
        v.ev = ev; v.ed = ed; v.ep = ep; v.een = een; v.ea = ea;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic ev,
                             input logic [7:0] ed, input logic [4:0] ep,
                             input logic een, input logic [4:0] ea,
                             input logic eh);
        chk({tag, " valid"}, 32'(core_if.instr_valid), 32'(ev));
        if (ev) begin
            chk({tag, " data"}, 32'(core_if.instr_data), 32'(ed));
            chk({tag, " pc"}, 32'(core_if.instr_pc), 32'(ep));
        end
        chk({tag, " rom_en"}, 32'(rom_enable_out), 32'(een));
        chk({tag, " rom_addr"}, 32'(rom_addr), 32'(ea));
        chk({tag, " halted"}, 32'(halted), 32'(eh));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom_mem[i] = 8'hA0 + 8'(i);
        rom_mem[0] = 8'd65; rom_mem[1] = 8'd83; rom_mem[2] = 8'd82;
        rom_mem[3] = 8'd77; rom_mem[4] = 8'd20; rom_mem[5] = 8'd60;
        rom_mem[21] = 8'h0E;

        reset = 1'b0;
        jump = 1'b0;
        jump_addr = '0;
        core_if.instr_ready = 1'b0;

        // Reset values, including zeroed head fields.
        step();
        step();
        chk("rst data", 32'(core_if.instr_data), 32'd0);
        chk("rst pc", 32'(core_if.instr_pc), 32'd0);
        check_out("rst", 0, 0, 0, 0, 5'd0, 0);

        // Streaming from reset with ready held high.
        vecs.push_back(mk(0,1,0,0, 0,0,0,     0,0));
        vecs.push_back(mk(0,1,0,0, 0,0,0,     0,0));
        vecs.push_back(mk(1,1,0,0, 0,0,0,     1,1));
        vecs.push_back(mk(1,1,0,0, 1,65,0,    1,2));
        vecs.push_back(mk(1,1,0,0, 1,83,1,    1,3));
        vecs.push_back(mk(1,1,0,0, 1,82,2,    1,4));
        vecs.push_back(mk(1,1,0,0, 1,77,3,    1,5));
        vecs.push_back(mk(1,1,0,0, 1,20,4,    1,6));
        // Backpressure: fill to DEPTH, then drain in order.
        vecs.push_back(mk(0,0,0,0, 0,0,0,     0,0));
        vecs.push_back(mk(1,0,0,0, 0,0,0,     1,1));
        vecs.push_back(mk(1,0,0,0, 1,65,0,    1,2));
        vecs.push_back(mk(1,0,0,0, 1,65,0,    1,3));
        vecs.push_back(mk(1,0,0,0, 1,65,0,    1,4));
        for (int k = 0; k < 6; k++)
            vecs.push_back(mk(1,0,0,0, 1,65,0, 0,4));
        vecs.push_back(mk(1,1,0,0, 1,83,1,    0,4));
        vecs.push_back(mk(1,1,0,0, 1,82,2,    1,5));
        vecs.push_back(mk(1,1,0,0, 1,77,3,    1,6));
        vecs.push_back(mk(1,1,0,0, 1,20,4,    1,7));
        vecs.push_back(mk(1,1,0,0, 1,60,5,    1,8));
        // Jump with 3 queued + 1 in flight, then jump+pop and wrap.
        vecs.push_back(mk(0,0,0,0, 0,0,0,     0,0));
        vecs.push_back(mk(1,0,0,0, 0,0,0,     1,1));
        vecs.push_back(mk(1,0,0,0, 1,65,0,    1,2));
        vecs.push_back(mk(1,0,0,0, 1,65,0,    1,3));
        vecs.push_back(mk(1,0,0,0, 1,65,0,    1,4));
        vecs.push_back(mk(1,0,1,18, 0,0,0,    0,18));
        vecs.push_back(mk(1,1,0,0, 0,0,0,     1,19));
        vecs.push_back(mk(1,1,0,0, 1,8'hB2,18, 1,20));
        vecs.push_back(mk(1,1,0,0, 1,8'hB3,19, 1,21));
        vecs.push_back(mk(1,1,1,30, 0,0,0,    0,30));
        vecs.push_back(mk(1,1,0,0, 0,0,0,     1,31));
        vecs.push_back(mk(1,1,0,0, 1,8'hBE,30, 1,0));
        vecs.push_back(mk(1,1,0,0, 1,8'hBF,31, 1,1));
        vecs.push_back(mk(1,1,0,0, 1,65,0,    1,2));
        vecs.push_back(mk(1,1,0,0, 1,83,1,    1,3));
        // Back-to-back jumps: the later target wins.
        vecs.push_back(mk(1,1,1,10, 0,0,0,    0,10));
        vecs.push_back(mk(1,1,1,25, 0,0,0,    0,25));
        vecs.push_back(mk(1,1,0,0, 0,0,0,     1,26));
        vecs.push_back(mk(1,1,0,0, 1,8'hB9,25, 1,27));
        // Reset mid-stream restarts at RESET_PC.
        vecs.push_back(mk(0,1,0,0, 0,0,0,     0,0));
        vecs.push_back(mk(1,1,0,0, 0,0,0,     1,1));
        vecs.push_back(mk(1,1,0,0, 1,65,0,    1,2));

        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            core_if.instr_ready = vecs[i].rdy;
            jump = vecs[i].jmp;
            jump_addr = vecs[i].ja;
            step();
            check_out($sformatf("row%0d", i), vecs[i].ev, vecs[i].ed,
                      vecs[i].ep, vecs[i].een, vecs[i].ea, 1'b0);
        end

        // Quit opcode at PC 21.
        reset = 1'b0; jump = 1'b0; core_if.instr_ready = 1'b1;
        step();
        reset = 1'b1; jump = 1'b1; jump_addr = 5'd20;
        step();
        check_out("q0", 0, 0, 0, 0, 5'd20, 0);
        jump = 1'b0;
        step();
        check_out("q1", 0, 0, 0, 1, 5'd21, 0);
        step();
        check_out("q2", 1, 8'hB4, 5'd20, 1, 5'd22, 0);
        step();
`ifdef PREFETCH_QUIT_STOP_EN
        check_out("q3", 1, 8'h0E, 5'd21, 0, 5'd22, 1);
        step();
        check_out("q4", 0, 0, 0, 0, 5'd22, 1);
        step();
        check_out("q5", 0, 0, 0, 0, 5'd22, 1);
`else
        check_out("q3", 1, 8'h0E, 5'd21, 1, 5'd23, 0);
        step();
        check_out("q4", 1, 8'hB6, 5'd22, 1, 5'd24, 0);
        step();
        check_out("q5", 1, 8'hB7, 5'd23, 1, 5'd25, 0);
`endif
        jump = 1'b1; jump_addr = 5'd0;
        step();
        check_out("q6", 0, 0, 0, 0, 5'd0, 0);
        jump = 1'b0;
        step();
        check_out("q7", 0, 0, 0, 1, 5'd1, 0);
        step();
        check_out("q8", 1, 8'd65, 5'd0, 1, 5'd2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_prefetch.md
Name: rom_prefetch

Overview:
- Instruction prefetch stage between a synchronous program ROM and the Reflet core decoder.
- Drives the ROM address and output-enable, absorbs the ROM's one-cycle registered read latency, and buffers fetched bytes in a small FIFO.
- Presents one instruction byte per cycle with its PC to the core through a valid/ready handshake.
- Supports flush-and-redirect on jump.

Parameters:
- ADDR_W, 5, ROM address width; PC wraps modulo 2^ADDR_W.
- WORD_W, 8, instruction byte width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- rom_addr  out  ADDR_W  address presented to the ROM; the ROM samples it at posedge.
- rom_enable_out  out  1  ROM output enable; high exactly in the cycle the ROM data is consumed.
- rom_data  in  WORD_W  ROM read data, valid in the cycle after the address edge.
- jump  in  1  redirect request, one cycle.
- jump_addr  in  ADDR_W  redirect target.
- instr_valid  out  1  FIFO head is valid.
- instr_data  out  WORD_W  FIFO head byte.
- instr_pc  out  ADDR_W  address of the FIFO head byte.
- instr_ready  in  1  core accepts the head; a pop occurs when instr_valid && instr_ready.
- halted  out  1  fetch stopped (see Optional Feature); otherwise constant 0.

Behaviour:
- Reset (reset==0 at posedge):
  - fetch_pc=RESET_PC, so rom_addr=RESET_PC.
  - inflight=0, rom_enable_out=0, FIFO count=0.
  - instr_valid=0, instr_data=0, instr_pc=0, halted=0.
- rom_addr is combinational from fetch_pc.
- Issue:
  - At a posedge where issue = reset && !jump && !halted && (count + inflight) < DEPTH, the ROM latches rom_addr.
  - On that edge: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1 (wraps from 2^ADDR_W-1 to 0).
  - If issue is false at an edge, inflight<=0.
- Capture:
  - rom_enable_out = inflight.
  - At the next posedge, if inflight && !jump, {rom_data, inflight_pc} is pushed to the FIFO.
- Throughput: one byte per cycle in steady state.
- Latency: first instr_valid=1 in the 2nd cycle after reset deassertion (issue at edge 1, capture at edge 2).
- The credit rule counts the in-flight request, so a push never finds the FIFO full. Overflow is impossible by construction; an assertion checks it.
- Simultaneous push and pop: both take effect; count is unchanged.
- Pop on empty is ignored (instr_valid=0).
- Jump at a posedge:
  - FIFO cleared, in-flight result discarded, inflight<=0.
  - fetch_pc<=jump_addr; no issue on that edge.
  - Jump wins over a simultaneous pop/push.
  - instr_valid=0 in the next cycle; the first byte from jump_addr is valid 2 cycles after the jump edge.
- Back-to-back jumps: the last one wins.
- Reset mid-operation discards everything identically to power-up reset.

Optional Feature:
- Macro: PREFETCH_QUIT_STOP_EN.
- Defined:
  - When a captured byte equals 8'h0E (quit opcode), it is pushed and halted<=1.
  - No further issues occur until jump or reset, both of which clear halted.
  - Bytes already in the FIFO remain poppable.
- Undefined:
  - halted is tied 0.
  - Fetching continues through 0x0E and wraps the address space.

Decomposition:
- Shared package: QUIT_OPCODE (8'h0E), defaults for ADDR_W/WORD_W.
- One sub-module: prefetch_fifo.
  - Parameterised DEPTH x (WORD_W+ADDR_W).
  - Synchronous clear input.
  - Count output of $clog2(DEPTH)+1 bits.
  - First-word-fall-through head.
- The top level holds fetch_pc, the inflight bookkeeping and the halt logic.

Test Plan:
- ROM model with bytes 65,83,82,77,20,60; release reset, instr_ready=1 -> instr_valid rises cycle 2; pops 65@0, 83@1, 82@2, 77@3 on consecutive cycles.
- instr_ready=0 for 10 cycles -> count saturates at 4, rom_enable_out low once full; release -> bytes at PCs 0..3 then 4 delivered in order, none lost or duplicated.
- Jump to jump_addr=18 while FIFO holds 3 entries and a request is in flight -> next cycle instr_valid=0; 2 cycles later head is the byte at PC 18; stale bytes never appear.
- Fetch starting at PC 30 with DEPTH free -> PCs delivered 30, 31, 0, 1 (wrap).
- Jump and pop in the same cycle, and reset asserted mid-stream -> FIFO empty next cycle, rom_enable_out=0, fetch resumes from jump_addr or RESET_PC respectively.
- With PREFETCH_QUIT_STOP_EN, ROM byte 0x0E at PC 21 -> halted=1 after capture, rom_enable_out stays 0, byte 0x0E@21 still delivered; a jump to 0 clears halted and refetches from 0.
